qdiv_seq: RTL and testbench

Parametrised sequential fixed-point divider for sign-magnitude (Q,N) operands. It computes one quotient bit per clock with a restoring algorithm and uses a ready/valid handshake on both the input and the result. It reports overflow and divide-by-zero, and can optionally saturate. It sits in the fixed-point math library beside the multiplier and adder, and is intended for datapaths that tolerate multi-cycle latency in exchange for small area.

---
 rtl/qdiv_pkg.sv | 24 ++
 rtl/qdiv_seq_if.sv | 24 ++
 rtl/qdiv_step.sv | 18 +
 rtl/qdiv_seq.sv | 167 ++++++++++++++++
 tb/tb_qdiv_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/qdiv_pkg.sv
// Shared types and helpers for the sequential sign-magnitude fixed-point divider.
// Holds the FSM state enum, the iteration-counter width helper and the sign/magnitude field accessors.
package qdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n, input int q);
    return $clog2(n + q);
  endfunction

  // Operands are passed zero-extended to 64 bits; n is the real word width.
  function automatic logic sm_sign(input logic [63:0] x, input int n);
    return |(x & (64'd1 << (n - 1)));
  endfunction

  function automatic logic [63:0] sm_mag(input logic [63:0] x, input int n);
    return x & ((64'd1 << (n - 1)) - 64'd1);
  endfunction

endpackage

// File: rtl/qdiv_seq_if.sv
// Request/result handshake bundle for qdiv_seq; master drives operands, slave is the divider.
interface qdiv_seq_if #(
  parameter int N = 32
);
  logic         i_start;
  logic         o_ready;
  logic [N-1:0] i_dividend;
  logic [N-1:0] i_divisor;
  logic         o_valid;
  logic         i_out_ready;
  logic [N-1:0] o_quotient;
  logic         o_overflow;
  logic         o_dbz;

  modport master (
    output i_start, i_dividend, i_divisor, i_out_ready,
    input  o_ready, o_valid, o_quotient, o_overflow, o_dbz
  );

  modport slave (
    input  i_start, i_dividend, i_divisor, i_out_ready,
    output o_ready, o_valid, o_quotient, o_overflow, o_dbz
  );
endinterface

// File: rtl/qdiv_step.sv
// One restoring-division step: compare the remainder with the pre-shifted divisor and subtract on >=.
module qdiv_step #(
  parameter int RW = 46,
  parameter int DW = 76
) (
  input  logic [RW-1:0] rem,
  input  logic [DW-1:0] dsh,
  output logic [RW-1:0] rem_nxt,
  output logic          q_bit
);

  // The shifted divisor is wider than the remainder; high bits only matter for the compare.
  always_comb begin
    q_bit   = ({{(DW-RW){1'b0}}, rem} >= dsh);
    rem_nxt = q_bit ? (rem - dsh[RW-1:0]) : rem;
  end

endmodule

// File: rtl/qdiv_seq.sv
// Sequential restoring divider for sign-magnitude (Q,N) operands, one quotient bit per clock.
// Build option: define QDIV_SATURATE_EN to clamp the magnitude to all ones on overflow or divide-by-zero.
//
// state | meaning
// IDLE  | o_ready high, waiting for i_start
// RUN   | one restoring iteration per clock, cnt_q counts down to 0
// DONE  | result registered; o_valid held until i_out_ready
module qdiv_seq
  import qdiv_pkg::*;
#(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  qdiv_seq_if.slave  bus
);

  localparam int W  = N + Q - 1;
  localparam int DW = N + W - 2;
  localparam int CW = cnt_width(N, Q);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [DW-1:0]  dsh_q, dsh_d;
  logic [W-2:0]   quo_q, quo_d;
  logic           sign_q, sign_d;
  logic [N-1:0]   res_q, res_d;
  logic           ovf_q, ovf_d;
  logic           dbz_q, dbz_d;
  logic           valid_q, valid_d;

  logic [W-1:0]   rem_nxt;
  logic           q_bit;
  logic [W-1:0]   raw;
  logic           raw_ovf;
  logic [N-2:0]   mag;
  logic [N-2:0]   a_mag;
  logic [N-2:0]   v_mag;
  logic           in_sign;

  qdiv_step #(
    .RW (W),
    .DW (DW)
  ) u_step (
    .rem     (rem_q),
    .dsh     (dsh_q),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  always_comb begin
    a_mag   = (N-1)'(sm_mag(64'(bus.i_dividend), N));
    v_mag   = (N-1)'(sm_mag(64'(bus.i_divisor), N));
    in_sign = sm_sign(64'(bus.i_dividend), N) ^ sm_sign(64'(bus.i_divisor), N);

    // Raw quotient as it will look once the current (last) bit is shifted in.
    raw     = {quo_q, q_bit};
    raw_ovf = |raw[W-1:N-1];
    mag     = raw[N-2:0];
`ifdef QDIV_SATURATE_EN
    if (raw_ovf) begin
      mag = '1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dsh_d   = dsh_q;
    quo_d   = quo_q;
    sign_d  = sign_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          rem_d  = {a_mag, {Q{1'b0}}};
          dsh_d  = {v_mag, {(W-1){1'b0}}};
          quo_d  = '0;
          cnt_d  = CW'(W - 1);
          sign_d = in_sign;
          ovf_d  = 1'b0;
          if (v_mag == '0) begin
            state_d = DONE;
            dbz_d   = 1'b1;
`ifdef QDIV_SATURATE_EN
            res_d   = {in_sign, {(N-1){1'b1}}};
`else
            res_d   = '0;
`endif
          end else begin
            state_d = RUN;
            dbz_d   = 1'b0;
          end
        end
      end

      RUN: begin
        rem_d = rem_nxt;
        dsh_d = dsh_q >> 1;
        quo_d = {quo_q[W-3:0], q_bit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          valid_d = 1'b1;
          ovf_d   = raw_ovf;
          res_d   = {sign_q & (|mag), mag};
        end
      end

      // Divide-by-zero enters DONE with valid low, so o_valid rises one cycle after accept.
      DONE: begin
        if (valid_q && bus.i_out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dsh_q   <= '0;
      quo_q   <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dsh_q   <= dsh_d;
      quo_q   <= quo_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_ready    = (state_q == IDLE);
  assign bus.o_valid    = valid_q;
  assign bus.o_quotient = res_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_dbz      = dbz_q;

endmodule

// File: tb/tb_qdiv_seq.sv
// Directed bench for qdiv_seq at Q=15, N=32 with a division-operator reference and a result scoreboard.
module tb_qdiv_seq;
  localparam int N = 32;
  localparam int Q = 15;
  localparam int LAT = N + Q - 1;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;

  qdiv_seq_if #(.N(N)) bus ();

  qdiv_seq #(.Q(Q), .N(N)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [N-1:0] q;
    logic         ovf;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [N-1:0] last_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    logic [63:0] d, v, r, mag;
    logic s;
    d = 64'(a[N-2:0]);
    v = 64'(b[N-2:0]);
    s = a[N-1] ^ b[N-1];
    e = '0;
    if (v == 64'd0) begin
      e.dbz = 1'b1;
`ifdef QDIV_SATURATE_EN
      e.q = {s, {(N-1){1'b1}}};
`endif
    end else begin
      r     = (d << Q) / v;
      e.ovf = (r >> (N - 1)) != 64'd0;
      mag   = r & ((64'd1 << (N - 1)) - 64'd1);
`ifdef QDIV_SATURATE_EN
      if (e.ovf) mag = (64'd1 << (N - 1)) - 64'd1;
`endif
      e.q = {s && (mag != 64'd0), mag[N-2:0]};
    end
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int exp_lat, input int hold);
    int lat;
    exp_t e;
    @(negedge i_clk);
    chk({tag, "_ready"}, 64'(bus.o_ready), 64'd1);
    bus.i_start    = 1'b1;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    sb.push_back(model(a, b));
    @(posedge i_clk);
    #1;
    bus.i_start    = 1'b0;
    bus.i_dividend = $urandom;
    bus.i_divisor  = $urandom;
    lat = 0;
    while (!bus.o_valid && lat < 200) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'(sb.size()), 64'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    chk({tag, "_quot"}, 64'(bus.o_quotient), 64'(e.q));
    chk({tag, "_ovf"}, 64'(bus.o_overflow), 64'(e.ovf));
    chk({tag, "_dbz"}, 64'(bus.o_dbz), 64'(e.dbz));
    last_q = bus.o_quotient;
    for (int i = 0; i < hold; i++) begin
      bus.i_start    = 1'b1;
      bus.i_dividend = $urandom;
      bus.i_divisor  = $urandom;
      @(posedge i_clk);
      #1;
      chk({tag, "_hold_valid"}, 64'(bus.o_valid), 64'd1);
      chk({tag, "_hold_ready"}, 64'(bus.o_ready), 64'd0);
      chk({tag, "_hold_quot"}, 64'(bus.o_quotient), 64'(e.q));
      chk({tag, "_hold_flags"}, 64'({bus.o_overflow, bus.o_dbz}), 64'({e.ovf, e.dbz}));
    end
    bus.i_start     = 1'b0;
    bus.i_out_ready = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_out_ready = 1'b0;
    chk({tag, "_post_valid"}, 64'(bus.o_valid), 64'd0);
    chk({tag, "_post_ready"}, 64'(bus.o_ready), 64'd1);
  endtask

  initial begin
    int stray;
    bus.i_start     = 1'b0;
    bus.i_dividend  = '0;
    bus.i_divisor   = '0;
    bus.i_out_ready = 1'b0;

    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ready", 64'(bus.o_ready), 64'd1);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_quot", 64'(bus.o_quotient), 64'd0);
    chk("rst_flags", 64'({bus.o_overflow, bus.o_dbz}), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    run_op("basic", 32'h0001_8000, 32'h0001_0000, LAT, 0);
    chk("basic_const", 64'(last_q), 64'h0000_C000);
    run_op("mixed", 32'h8000_C000, 32'h0000_4000, LAT, 0);
    chk("mixed_const", 64'(last_q), 64'h8001_8000);
    run_op("negzero", 32'h8000_0000, 32'h0000_8000, LAT, 0);
    chk("negzero_const", 64'(last_q), 64'h0000_0000);
    run_op("ovf", 32'h7FFF_FFFF, 32'h0000_0001, LAT, 0);
`ifdef QDIV_SATURATE_EN
    chk("ovf_const", 64'(last_q), 64'h7FFF_FFFF);
`else
    chk("ovf_const", 64'(last_q), 64'h7FFF_8000);
`endif
    run_op("dbz", 32'h0002_8000, 32'h8000_0000, 1, 0);
`ifdef QDIV_SATURATE_EN
    chk("dbz_const", 64'(last_q), 64'hFFFF_FFFF);
`else
    chk("dbz_const", 64'(last_q), 64'h0000_0000);
`endif

    run_op("bp", 32'h8003_0000, 32'h0000_6000, LAT, 20);
    run_op("bp_next", 32'h0000_4000, 32'h8000_C000, LAT, 0);

    // Reset in the middle of an operation.
    @(negedge i_clk);
    bus.i_start    = 1'b1;
    bus.i_dividend = 32'h0001_8000;
    bus.i_divisor  = 32'h0001_0000;
    sb.push_back(model(32'h0001_8000, 32'h0001_0000));
    @(posedge i_clk);
    #1;
    bus.i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.o_valid), 64'd0);
    chk("midrst_ready", 64'(bus.o_ready), 64'd1);
    chk("midrst_quot", 64'(bus.o_quotient), 64'd0);
    chk("midrst_flags", 64'({bus.o_overflow, bus.o_dbz}), 64'd0);
    sb.delete();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    stray = 0;
    repeat (60) begin
      @(posedge i_clk);
      #1;
      if (bus.o_valid) stray++;
    end
    chk("midrst_no_stray", 64'(stray), 64'd0);
    run_op("after_rst", 32'h0001_8000, 32'h0001_0000, LAT, 0);
    chk("after_rst_const", 64'(last_q), 64'h0000_C000);

    for (int i = 0; i < 4; i++) begin
      logic [N-1:0] a, b;
      a = $urandom;
      b = $urandom;
      b[N-2:N-8] = 7'd0;
      if (b[N-2:0] == '0) b[0] = 1'b1;
      run_op("rand", a, b, LAT, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
